// File: rtl/pio_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : pio_input_conditioner
// Function : Per-bit 2-FF synchronizer, counter debounce, polarity inversion
//            and registered change pulses for a PCIe core's input PIO port.
// Option   : define PIO_INPUT_CONDITIONER_EDGE_CAPTURE_EN for sticky capture.
// Revision : 1.0 - initial release
// ============================================================================
module pio_input_conditioner #(
    parameter int                 WIDTH           = 32,
    parameter int                 DEBOUNCE_CYCLES = 250000,
    parameter logic [WIDTH-1:0]   INVERT_MASK     = '0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [WIDTH-1:0]   raw_in,
    input  logic [WIDTH-1:0]   clr,
    output logic [WIDTH-1:0]   pio_out,
    output logic [WIDTH-1:0]   rise,
    output logic [WIDTH-1:0]   fall,
    output logic               any_change,
    output logic [WIDTH-1:0]   capture
);

    localparam int             CW        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  C_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  C_CNT_ONE = CW'(1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync_q;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_pio;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_any;
    logic [CW-1:0]    r_cnt [WIDTH];

    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] w_stable_nxt;
    logic [WIDTH-1:0] w_pio_nxt;

    // Each bit debounces independently; a match with the stable level
    // zeroes the count so any bounce restarts the full interval.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign w_accept[gi] = (r_sync_q[gi] != r_stable[gi]) && (r_cnt[gi] == C_CNT_MAX);

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_cnt[gi] <= '0;
            end else if (r_sync_q[gi] == r_stable[gi]) begin
                r_cnt[gi] <= '0;
            end else if (r_cnt[gi] == C_CNT_MAX) begin
                r_cnt[gi] <= '0;
            end else begin
                r_cnt[gi] <= r_cnt[gi] + C_CNT_ONE;
            end
        end
    end

    // Output and pulses are computed from the next stable value so they
    // update on the same edge that accepts the new level.
    assign w_stable_nxt = r_stable ^ w_accept;
    assign w_pio_nxt    = w_stable_nxt ^ INVERT_MASK;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1  <= '0;
            r_sync_q <= '0;
            r_stable <= '0;
            r_pio    <= INVERT_MASK;
            r_rise   <= '0;
            r_fall   <= '0;
            r_any    <= 1'b0;
        end else begin
            r_sync1  <= raw_in;
            r_sync_q <= r_sync1;
            r_stable <= w_stable_nxt;
            r_pio    <= w_pio_nxt;
            r_rise   <= w_pio_nxt & ~r_pio;
            r_fall   <= ~w_pio_nxt & r_pio;
            r_any    <= |(w_pio_nxt ^ r_pio);
        end
    end

    assign pio_out    = r_pio;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign any_change = r_any;

`ifdef PIO_INPUT_CONDITIONER_EDGE_CAPTURE_EN
    logic [WIDTH-1:0] r_capture;

    // A rise in the same cycle as a clear wins, so no edge is ever lost.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_capture <= '0;
        end else begin
            r_capture <= (r_capture & ~clr) | r_rise;
        end
    end

    assign capture = r_capture;
`else
    logic w_unused_clr;

    assign w_unused_clr = ^clr;
    assign capture      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pio_input_conditioner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pio_input_conditioner
// Function : Scoreboard bench for pio_input_conditioner (DEBOUNCE_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pio_input_conditioner;

    localparam int          DC   = 4;
    localparam int          LAT  = DC + 2;
    localparam logic [31:0] MASK = 32'h0000_000F;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] raw_in;
    logic [31:0] clr;
    logic [31:0] pio_out;
    logic [31:0] rise;
    logic [31:0] fall;
    logic        any_change;
    logic [31:0] capture;

    always #5 clk = ~clk;

    pio_input_conditioner #(
        .WIDTH           (32),
        .DEBOUNCE_CYCLES (DC),
        .INVERT_MASK     (MASK)
    ) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .raw_in     (raw_in),
        .clr        (clr),
        .pio_out    (pio_out),
        .rise       (rise),
        .fall       (fall),
        .any_change (any_change),
        .capture    (capture)
    );

    typedef struct {
        int          cyc;
        logic [31:0] pio;
        logic [31:0] rise;
        logic [31:0] fall;
    } ev_t;

    ev_t         q[$];
    ev_t         m_ev;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] cur_pio = MASK;
    logic [31:0] m_pio = MASK;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Events are popped either when the DUT pulses or when they fall due.
    always @(negedge clk) begin
        if (mon_en) begin
            if (any_change || (q.size() > 0 && q[0].cyc <= cyc)) begin
                if (q.size() == 0) begin
                    check_val("spurious_any_change", {31'b0, any_change}, 32'h0);
                end else begin
                    m_ev = q.pop_front();
                    check_val("ev_cycle", cyc, m_ev.cyc);
                    check_val("ev_pio", pio_out, m_ev.pio);
                    check_val("ev_rise", rise, m_ev.rise);
                    check_val("ev_fall", fall, m_ev.fall);
                    check_val("ev_any", {31'b0, any_change}, 32'h1);
                    cur_pio = m_ev.pio;
                end
            end else begin
                check_val("idle_pio", pio_out, cur_pio);
                check_val("idle_pulse", rise | fall, 32'h0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic settle();
        step(LAT + 3);
        check_val("drain", 32'(q.size()), 32'h0);
    endtask

    task automatic push_ev(input logic [31:0] np, input logic [31:0] op);
        ev_t e;
        e.cyc  = cyc + LAT;
        e.pio  = np;
        e.rise = np & ~op;
        e.fall = ~np & op;
        q.push_back(e);
    endtask

    task automatic drive(input logic [31:0] raw_v);
        logic [31:0] np;
        raw_in = raw_v;
        np     = raw_v ^ MASK;
        if (np != m_pio) push_ev(np, m_pio);
        m_pio = np;
    endtask

    task automatic do_reset(input logic [31:0] raw_v);
        mon_en = 1'b0;
        rstn   = 1'b0;
        raw_in = raw_v;
        #1;
        check_val("rst_pio", pio_out, MASK);
        check_val("rst_rise", rise, 32'h0);
        check_val("rst_fall", fall, 32'h0);
        check_val("rst_any", {31'b0, any_change}, 32'h0);
        check_val("rst_capture", capture, 32'h0);
        step(2);
        q.delete();
        cur_pio = MASK;
        m_pio   = MASK;
        rstn    = 1'b1;
        mon_en  = 1'b1;
        drive(raw_v);
    endtask

    initial begin
        rstn   = 1'b0;
        raw_in = 32'h0;
        clr    = 32'h0;
        @(negedge clk);

        do_reset(32'h0);
        step(10);

        // Inverted bit 1 goes high: output bit falls
        drive(32'h0000_0002);
        settle();

        // Clean step on a non-inverted bit
        drive(32'h0000_0102);
        settle();

        // Bounce on bit 16 never reaches acceptance
        raw_in = 32'h0001_0102; step(2);
        raw_in = 32'h0000_0102; step(2);
        raw_in = 32'h0001_0102; step(2);
        raw_in = 32'h0000_0102; step(2);
        drive(32'h0001_0102);
        settle();

        // Simultaneous fall on bit 8 and rise on bit 20
        drive(32'h0011_0002);
        settle();

`ifdef PIO_INPUT_CONDITIONER_EDGE_CAPTURE_EN
        drive(32'h0011_0022);
        settle();
        check_val("cap_first", capture & 32'h20, 32'h20);
        drive(32'h0011_0002);
        settle();
        drive(32'h0011_0022);
        wait_until(cyc + LAT);
        clr = 32'h20;
        step(1);
        clr = 32'h0;
        check_val("cap_set_wins", capture & 32'h20, 32'h20);
        step(3);
        clr = 32'h20;
        step(1);
        clr = 32'h0;
        check_val("cap_clr", capture & 32'h20, 32'h0);
        drive(32'h0011_0002);
        settle();
`else
        clr = 32'hFFFF_FFFF;
        drive(32'h0011_0022);
        settle();
        check_val("cap_tied", capture, 32'h0);
        clr = 32'h0;
        drive(32'h0011_0002);
        settle();
`endif

        // Reset part-way through a debounce interval on bit 2
        raw_in = 32'h0011_0006;
        step(3);
        do_reset(32'h0011_0006);
        settle();

        // Reset with every input high
        do_reset(32'hFFFF_FFFF);
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/pio_input_conditioner.md
Name: pio_input_conditioner

Overview:
- Conditions raw board inputs (push-buttons, slide switches) before they reach the PCIe core's 32-bit input PIO ports (button and general input PIOs).
- Per bit: 2-FF synchronizer, counter-based debounce, optional polarity inversion, one-cycle change pulses.
- Host software therefore reads glitch-free, clock-domain-safe values over PCIe.
- One instance per PIO input port, clocked from the core's reference clock domain.

Parameters:
- WIDTH, 32, number of conditioned bits.
- DEBOUNCE_CYCLES, 250000, cycles a synchronized input must differ from the stable value before it is accepted (5 ms at 50 MHz); legal range 2..2^24.
- INVERT_MASK, 32'h0, per-bit XOR applied to the stable value on output (1 = active-low key).

Ports:
- clk  in  1  single clock for all logic.
- rstn  in  1  asynchronous, active-low reset.
- raw_in  in  WIDTH  asynchronous board inputs.
- clr  in  WIDTH  write-1-to-clear strobe for capture bits (used only with EDGE_CAPTURE_EN).
- pio_out  out  WIDTH  debounced, inverted value; feeds the PIO input port.
- rise  out  WIDTH  one-cycle pulse per bit when pio_out bit goes 0->1.
- fall  out  WIDTH  one-cycle pulse per bit when pio_out bit goes 1->0.
- any_change  out  1  one-cycle pulse, OR of rise|fall.
- capture  out  WIDTH  sticky rising-edge flags.

Behaviour:
- Reset (rstn low, asynchronous):
  - sync stages, stable, counters and capture all cleared to 0.
  - pio_out = INVERT_MASK; rise, fall and any_change = 0.
  - No rise or fall is generated on reset release.
- Synchronizer: sync1 <= raw_in; sync_q <= sync1. All further logic uses sync_q only.
- Debounce, per bit i, counter width $clog2(DEBOUNCE_CYCLES):
  - If sync_q[i] == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= sync_q[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- A bounce that returns to the stable level before acceptance zeroes the counter; the full interval restarts on the next mismatch.
- Latency: a clean step on raw_in appears on pio_out on the (DEBOUNCE_CYCLES+2)th rising clk edge, counting the first edge that samples the new level. Equivalently, DEBOUNCE_CYCLES+2 cycles.
- pio_out = stable ^ INVERT_MASK, registered with no extra combinational path.
- rise, fall and any_change are registered. They assert in the same cycle pio_out changes and last exactly 1 cycle.
- Bits are fully independent. Several bits accepting in the same cycle produce simultaneous rise/fall bits and a single any_change pulse.
- Counter never wraps; its maximum value is DEBOUNCE_CYCLES-1.
- Reset mid-count discards partial counts; no pulse is produced.

Optional Feature:
- Macro: PIO_INPUT_CONDITIONER_EDGE_CAPTURE_EN.
- Defined:
  - capture[i] sets on rise[i] and clears when clr[i] = 1.
  - Set and clear in the same cycle: set wins, and the bit stays 1.
  - Reset value 0.
- Undefined: capture is tied to 0, clr is ignored, and no capture flops are synthesized.

Test Plan:
- Reset with DEBOUNCE_CYCLES=4, INVERT_MASK=0: hold rstn low, raw_in=32'hFFFFFFFF, then release -> pio_out=0 until the 6th edge after release, then 32'hFFFFFFFF; rise=32'hFFFFFFFF for 1 cycle; no fall.
- Clean step, DEBOUNCE_CYCLES=4: raw_in[0] 0->1 -> pio_out[0]=1 exactly 6 edges later; rise[0] and any_change high for 1 cycle; other bits unchanged.
- Bounce, DEBOUNCE_CYCLES=4: raw_in[3] toggles 1,0,1,0 every 2 cycles, then holds 1 -> pio_out[3] stays 0 during bouncing and becomes 1 6 edges after the final edge.
- Invert, INVERT_MASK=32'h0000000F: after reset pio_out=32'h0000000F; raw_in[1] held 1 for 6 cycles -> pio_out=32'h0000000D with fall[1] pulse.
- Edge capture (macro on): raw_in[5] rises -> capture[5]=1. Assert clr[5] in the same cycle as a second rise[5] -> capture[5] stays 1. Lone clr[5] -> capture[5]=0 next cycle.
- Reset mid-operation: raw_in[2] held high for 3 cycles (DEBOUNCE_CYCLES=4), then rstn pulsed low -> pio_out[2]=0 and no rise. After release with raw_in[2] still 1, it is accepted after a fresh 6-edge interval.
